// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: picks PC+4, hold, redirect or halt each cycle and drives
// the instruction-memory request, IF/ID enable and pipeline flush.
module pc_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        iren,
    output logic [31:0] iaddr,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush,
    output logic        halted
);

    typedef enum logic [1:0] {RUN, REDIR_WAIT, HALT} state_t;

    state_t      state, state_nxt;
    logic [29:0] pc, pc_nxt;
    logic [29:0] pending_pc, pending_nxt;
    logic [29:0] tgt;
    logic        unused_lo;

    assign tgt       = redirect_pc[31:2];
    assign unused_lo = &redirect_pc[1:0];
    assign iaddr     = {pc, 2'b00};
    assign pc_plus4  = {pc + 30'd1, 2'b00};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            pc         <= PC_INIT[31:2];
            pending_pc <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending_pc;
        iren        = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        halted      = 1'b0;
        if (!RST) begin
            case (state)
                RUN: begin
                    iren = 1'b1;
                    if (halt) begin
                        flush     = 1'b1;
                        state_nxt = HALT;
                    end else if (redirect) begin
                        flush = 1'b1;
                        // Without ihit the request is in flight: keep iaddr steady, park the target.
                        if (ihit) begin
                            pc_nxt = tgt;
                        end else begin
                            pending_nxt = tgt;
                            state_nxt   = REDIR_WAIT;
                        end
                    end else if (ihit && !stall) begin
                        fetch_valid = 1'b1;
                        pc_nxt      = pc + 30'd1;
                    end
                end
                REDIR_WAIT: begin
                    iren = 1'b1;
                    if (halt) begin
                        flush     = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        if (redirect) begin
                            flush       = 1'b1;
                            pending_nxt = tgt;
                        end
                        if (ihit) begin
                            pc_nxt    = redirect ? tgt : pending_pc;
                            state_nxt = RUN;
                        end
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan sequences with literal expectations,
// then random traffic checked every cycle against a behavioural fetch model.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST, ihit, stall, redirect, halt;
    logic [31:0] redirect_pc;

    logic        iren, fetch_valid, flush, halted;
    logic [31:0] iaddr, pc_plus4;
    logic        iren1, fetch_valid1, flush1, halted1;
    logic [31:0] iaddr1, pc_plus41;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pc_sequencer dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .iren(iren), .iaddr(iaddr),
        .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .flush(flush), .halted(halted)
    );

    pc_sequencer #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .iren(iren1), .iaddr(iaddr1),
        .pc_plus4(pc_plus41), .fetch_valid(fetch_valid1), .flush(flush1), .halted(halted1)
    );

    // Behavioural model: mode 0 = fetching, 1 = waiting out an in-flight fetch
    // before jumping, 2 = halted.
    int          m_mode = 0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_pend = '0;
    bit          m_live = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic        e_iren, e_fv, e_fl, e_halted;
        logic [31:0] tgt;
        tgt      = redirect_pc & 32'hFFFF_FFFC;
        e_iren   = 1'b0;
        e_fv     = 1'b0;
        e_fl     = 1'b0;
        e_halted = 1'b0;
        if (RST) begin
            m_live = 1'b1;
            cmp("m_iren", {31'b0, iren}, 0);
            cmp("m_fv", {31'b0, fetch_valid}, 0);
            cmp("m_flush", {31'b0, flush}, 0);
            cmp("m_halted", {31'b0, halted}, 0);
            m_mode = 0;
            m_pc   = 32'h0;
            m_pend = 32'h0;
        end else if (m_live) begin
            if (m_mode == 2) begin
                e_halted = 1'b1;
            end else begin
                e_iren = 1'b1;
                if (halt) begin
                    e_fl = 1'b1;
                end else if (redirect) begin
                    e_fl = 1'b1;
                end else if (m_mode == 0 && ihit && !stall) begin
                    e_fv = 1'b1;
                end
            end
            cmp("m_iren", {31'b0, iren}, {31'b0, e_iren});
            cmp("m_fv", {31'b0, fetch_valid}, {31'b0, e_fv});
            cmp("m_flush", {31'b0, flush}, {31'b0, e_fl});
            cmp("m_halted", {31'b0, halted}, {31'b0, e_halted});
            cmp("m_iaddr", iaddr, m_pc);
            cmp("m_pc_plus4", pc_plus4, m_pc + 32'd4);
            // Advance the model to what the next cycle must show.
            if (m_mode != 2) begin
                if (halt) begin
                    m_mode = 2;
                end else if (m_mode == 0) begin
                    if (redirect && ihit) m_pc = tgt;
                    else if (redirect) begin
                        m_pend = tgt;
                        m_mode = 1;
                    end else if (ihit && !stall) m_pc = m_pc + 32'd4;
                end else begin
                    if (ihit) begin
                        m_pc   = redirect ? tgt : m_pend;
                        m_mode = 0;
                    end else if (redirect) m_pend = tgt;
                end
            end
        end
    end

    task automatic drive(input bit r, input bit h, input bit s, input bit rd,
                         input logic [31:0] rp, input bit ht);
        @(posedge CLK);
        #1;
        RST = r; ihit = h; stall = s; redirect = rd; redirect_pc = rp; halt = ht;
        #1;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        cmp("rst_iren", {31'b0, iren}, 0);
        cmp("rst_halted", {31'b0, halted}, 0);

        // Sequential fetch, plus the wrap instance alongside
        drive(0, 1, 0, 0, 0, 0);
        cmp("seq0_iaddr", iaddr, 32'h0);
        cmp("seq0_fv", {31'b0, fetch_valid}, 1);
        cmp("seq0_iren", {31'b0, iren}, 1);
        cmp("wrap_iaddr", iaddr1, 32'hFFFF_FFFC);
        cmp("wrap_plus4", pc_plus41, 32'h0);
        drive(0, 1, 0, 0, 0, 0);
        cmp("seq1_iaddr", iaddr, 32'h4);
        cmp("wrap_next", iaddr1, 32'h0);
        drive(0, 1, 0, 0, 0, 0);
        cmp("seq2_iaddr", iaddr, 32'h8);
        drive(0, 1, 0, 0, 0, 0);
        cmp("seq3_iaddr", iaddr, 32'hC);
        cmp("seq3_flush", {31'b0, flush}, 0);

        // Stall holds the PC at 0x10
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            cmp("stall_iaddr", iaddr, 32'h10);
            cmp("stall_fv", {31'b0, fetch_valid}, 0);
        end
        drive(0, 1, 0, 0, 0, 0);
        cmp("unstall_fv", {31'b0, fetch_valid}, 1);
        drive(0, 1, 0, 0, 0, 0);
        cmp("unstall_iaddr", iaddr, 32'h14);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);

        // Redirect with ihit at 0x20
        drive(0, 1, 0, 1, 32'h103, 0);
        cmp("redir_pc", iaddr, 32'h20);
        cmp("redir_flush", {31'b0, flush}, 1);
        cmp("redir_fv", {31'b0, fetch_valid}, 0);
        drive(0, 1, 0, 1, 32'h40, 0);
        cmp("redir_tgt", iaddr, 32'h100);

        // Redirect while the fetch at 0x40 is outstanding, then a newer target
        drive(0, 0, 0, 1, 32'h200, 0);
        cmp("wait0_iaddr", iaddr, 32'h40);
        cmp("wait0_flush", {31'b0, flush}, 1);
        drive(0, 0, 0, 0, 0, 0);
        cmp("wait1_iaddr", iaddr, 32'h40);
        cmp("wait1_flush", {31'b0, flush}, 0);
        drive(0, 0, 0, 1, 32'h300, 0);
        cmp("wait2_flush", {31'b0, flush}, 1);
        drive(0, 1, 0, 0, 0, 0);
        cmp("wait3_iaddr", iaddr, 32'h40);
        cmp("wait3_fv", {31'b0, fetch_valid}, 0);
        cmp("wait3_flush", {31'b0, flush}, 0);
        drive(0, 0, 0, 0, 0, 0);
        cmp("wait_tgt", iaddr, 32'h300);

        // Halt beats redirect, then sticks
        drive(0, 1, 0, 1, 32'h500, 1);
        cmp("halt_flush", {31'b0, flush}, 1);
        drive(0, 1, 0, 1, 32'h600, 0);
        cmp("halt_halted", {31'b0, halted}, 1);
        cmp("halt_iren", {31'b0, iren}, 0);
        cmp("halt_iaddr", iaddr, 32'h300);
        drive(0, 1, 0, 0, 0, 0);
        cmp("halt_stick", iaddr, 32'h300);
        cmp("halt_flush0", {31'b0, flush}, 0);
        drive(1, 0, 0, 0, 0, 0);
        cmp("rst2_halted", {31'b0, halted}, 0);
        drive(0, 0, 0, 0, 0, 0);
        cmp("rst2_iaddr", iaddr, 32'h0);
        cmp("rst2_iren", {31'b0, iren}, 1);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom % 60) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
                  ($urandom % 6) == 0, $urandom, ($urandom % 150) == 0);
        end

        @(posedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the architectural PC register and sequences the next-PC path of the pipelined MIPS core. Each cycle it chooses among PC+4 advance, hold on stall or instruction-memory wait, a redirect resolved by the next-PC selector, and halt. It drives the instruction-memory request, the IF/ID latch enable and the pipeline flush. It sits between the instruction-memory port, the hazard unit and the next-PC selector.

## Interface
- PC_INIT, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00
- CLK  in  1  core clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction memory returns the word at iaddr this cycle
- stall  in  1  hazard unit freeze; IF/ID cannot accept a new instruction
- redirect  in  1  taken branch or jump resolved (pc_control from next-PC selector)
- redirect_pc  in  32  redirect target (nxt_pc from next-PC selector); bits [1:0] ignored, treated as 00
- halt  in  1  halt instruction reached writeback
- iren  out  1  instruction fetch request
- iaddr  out  32  current PC, sent to instruction memory
- pc_plus4  out  32  iaddr + 4, forwarded into IF/ID for link and branch-offset arithmetic
- fetch_valid  out  1  IF/ID latch enable; the fetched word is correct-path and accepted
- flush  out  1  squash IF/ID and ID/EX contents this cycle
- halted  out  1  core halted; sticky until reset

## Operation
- The PC register holds bits [31:2]; iaddr[1:0] is always 00.
- pc_plus4 = iaddr + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- States: RUN, REDIR_WAIT, HALT.
  - Holding registers: pending_pc (30 bits).
  - Reset value of pending_pc: 0.
- Priority within a cycle: RST > halt > redirect > ihit/stall.
- RST asserted:
  - Next state is RUN; PC <= PC_INIT; pending_pc <= 0.
  - During the reset cycle: iren=0, fetch_valid=0, flush=0, halted=0.
  - After reset: iaddr=PC_INIT and iren=1.
- RUN:
  - iren=1.
  - halt:
    - flush=1, fetch_valid=0, next state is HALT, PC held.
  - redirect & ihit:
    - flush=1; the fetched word is discarded (fetch_valid=0).
    - PC <= redirect_pc; stay in RUN.
  - redirect & !ihit:
    - flush=1.
    - pending_pc <= redirect_pc; next state is REDIR_WAIT.
    - PC and iaddr are held so the in-flight memory request stays stable.
  - ihit & !stall: fetch_valid=1, PC <= PC+4.
  - ihit & stall: fetch_valid=0, PC held. The same address is refetched.
  - !ihit: fetch_valid=0, PC held.
- REDIR_WAIT:
  - iren=1, iaddr = old PC (unchanged), fetch_valid=0 always.
  - halt: flush=1, next state is HALT.
  - redirect: pending_pc <= redirect_pc (the newer target overwrites), flush=1.
  - ihit: the word is discarded; PC <= pending_pc, or redirect_pc if redirect is asserted the same cycle; next state is RUN.
  - !ihit: stay.
- HALT:
  - iren=0, fetch_valid=0, flush=0, halted=1.
  - redirect, stall, ihit and halt are ignored.
  - Only RST leaves HALT.
- stall never blocks a redirect or halt; flush takes priority over stall in the IF/ID latch.

## Timing
- iren, iaddr, pc_plus4, fetch_valid, flush and halted are combinational from state, the PC and the current inputs. There are no registered output stages.
- Redirect with ihit the same cycle:
  - iaddr equals the target on the next cycle.
  - Redirect-to-target-fetch latency is 1 cycle.
- Redirect without ihit:
  - The target appears on iaddr the cycle after the in-flight ihit.
  - flush is asserted only in the redirect cycle(s), not while waiting.
- Sequential fetch: one instruction per cycle when ihit=1 and stall=0.
- halt to halted: halted=1 from the next cycle onward; iren drops the same cycle halted rises.
- Reset: output values are valid in the cycle after RST is sampled high; RST mid-REDIR_WAIT discards pending_pc.

## Test plan
- Reset, then ihit held at 1 and stall at 0 for 4 cycles: iaddr shows 0x0, 0x4, 0x8, 0xC; fetch_valid=1 in every cycle; flush=0 throughout.
- PC at 0x10 with ihit=1 and stall=1 for 3 cycles, then stall=0: iaddr stays 0x10 with fetch_valid=0 for 3 cycles, then fetch_valid=1 and iaddr becomes 0x14 on the next cycle.
- PC at 0x20 with redirect=1, redirect_pc=0x103 and ihit=1: flush=1 and fetch_valid=0 that cycle; next cycle iaddr=0x100.
- PC at 0x40, ihit=0, redirect=1 to 0x200, then a redirect to 0x300 two cycles later, then ihit=1 a cycle after that: iaddr stays 0x40 throughout; flush=1 only in the two redirect cycles; next iaddr=0x300.
- halt=1 with redirect=1 in the same cycle: flush=1; the next cycle has halted=1, iren=0 and the PC unchanged. Further redirect and ihit have no effect; RST returns iaddr to PC_INIT with halted=0.
- PC_INIT=0xFFFF_FFFC with ihit=1: pc_plus4=0x0, and the next iaddr=0x0.
